// File: rtl/aftab_resp_demux2_pkg.sv
// ---------------------------------------------------------------------------
// aftab_resp_demux2_pkg
//   Shared owner encodings for the memory port. The request-side 2:1 mux uses
//   the same values on its select input, so a tag recorded here matches the
//   requester that the mux granted.
//     AFTAB_REQ_I0 : instruction fetch
//     AFTAB_REQ_I1 : data access (LSU)
// ---------------------------------------------------------------------------
package aftab_resp_demux2_pkg;

    localparam logic AFTAB_REQ_I0 = 1'b0;
    localparam logic AFTAB_REQ_I1 = 1'b1;

endpackage : aftab_resp_demux2_pkg

// File: rtl/aftab_resp_demux2_tag_fifo.sv
// ---------------------------------------------------------------------------
// aftab_tag_fifo
//   Small in-order FIFO that records the owner tag of each issued request.
//   The head is presented combinationally so that a response can be routed
//   in the same cycle it arrives.
//   Ports:
//     clk   in   1              rising-edge clock
//     rst   in   1              synchronous reset, active-low
//     push  in   1              write din at the tail (ignored when full)
//     pop   in   1              drop the head entry (ignored when empty)
//     din   in   width          tag to store
//     dout  out  width          head tag, combinational
//     full  out  1              count == depth
//     empty out  1              count == 0
//     count out  clog2(depth+1) number of stored entries
// ---------------------------------------------------------------------------
module aftab_tag_fifo #(
    parameter int width = 1,
    parameter int depth = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [width-1:0]               din,
    output logic [width-1:0]               dout,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(depth+1)-1:0]     count
);

    localparam int PW = $clog2(depth);
    localparam int CW = $clog2(depth+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(depth);

    logic [width-1:0] r_mem [depth];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == FULL_CNT);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Pointers are exactly log2(depth) bits, so the +1 wraps mod depth for free.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read after
    // it was written, because dout is used only while count is non-zero.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule : aftab_tag_fifo

// File: rtl/aftab_resp_demux2.sv
// ---------------------------------------------------------------------------
// aftab_resp_demux2
//   Return path of the shared memory port. Each accepted request pushes its
//   owner (i0 = fetch, i1 = data) into a tag FIFO; each in-order response pops
//   the head tag and is steered to that owner as a registered data/valid pair
//   one cycle later. A response with nothing outstanding sets a sticky error.
//   Ports:
//     clk         in   1               rising-edge clock
//     rst         in   1               synchronous reset, active-low
//     reqValid    in   1               request issued to memory this cycle
//     reqSel      in   1               owner of that request
//     reqReady    out  1               tag queue not full (count only)
//     respValid   in   1               memory response this cycle
//     respData    in   size            response data
//     o0Valid     out  1               pulse: new response for i0
//     o0Data      out  size            last response routed to i0
//     o1Valid     out  1               pulse: new response for i1
//     o1Data      out  size            last response routed to i1
//     outstanding out  clog2(depth+1)  requests awaiting response
//     errOrphan   out  1               sticky: response with nothing outstanding
// ---------------------------------------------------------------------------
module aftab_resp_demux2
    import aftab_resp_demux2_pkg::*;
#(
    parameter int size  = 32,
    parameter int depth = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         reqValid,
    input  logic                         reqSel,
    output logic                         reqReady,
    input  logic                         respValid,
    input  logic [size-1:0]              respData,
    output logic                         o0Valid,
    output logic [size-1:0]              o0Data,
    output logic                         o1Valid,
    output logic [size-1:0]              o1Data,
    output logic [$clog2(depth+1)-1:0]   outstanding,
    output logic                         errOrphan
);

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_orphan;
    logic            w_head;
    logic            w_route0;
    logic            w_route1;
    logic            r_o0_valid;
    logic            r_o1_valid;
    logic [size-1:0] r_o0_data;
    logic [size-1:0] r_o1_data;
    logic            r_err_orphan;

    // Ready depends only on the stored count: a same-cycle response does not
    // free a slot for a same-cycle request.
    assign reqReady = !w_full;
    assign w_push   = reqValid && !w_full;
    // Emptiness is judged before this cycle's push, so a response can never
    // match a request issued in the same cycle.
    assign w_pop    = respValid && !w_empty;
    assign w_orphan = respValid && w_empty;

    aftab_tag_fifo #(
        .width (1),
        .depth (depth)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (reqSel),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (outstanding)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_route0 = 1'b0;
        w_route1 = 1'b0;
        if (w_pop) begin
            w_route0 = (w_head == AFTAB_REQ_I0);
            w_route1 = (w_head == AFTAB_REQ_I1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_o0_valid   <= 1'b0;
            r_o1_valid   <= 1'b0;
            r_o0_data    <= '0;
            r_o1_data    <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            r_o0_valid <= w_route0;
            r_o1_valid <= w_route1;
            // Data registers only load for their own owner and otherwise hold.
            if (w_route0) begin
                r_o0_data <= respData;
            end
            if (w_route1) begin
                r_o1_data <= respData;
            end
            if (w_orphan) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

    assign o0Valid   = r_o0_valid;
    assign o0Data    = r_o0_data;
    assign o1Valid   = r_o1_valid;
    assign o1Data    = r_o1_data;
    assign errOrphan = r_err_orphan;

endmodule : aftab_resp_demux2
